// File: rtl/cache_line_fill.sv
`default_nettype none
// ============================================================================
// Module  : cache_line_fill
// Purpose : Single-transaction line mover between the write-back cache and a
//           64-bit memory bus: optional victim writeback, then line refill.
// Revision: 1.0 - initial release
// ============================================================================
module cache_line_fill #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0] wb_data,
  output logic              ram_ready,
  output logic [LINE_W-1:0] ram_in,
  output logic              busy,
  output logic              err,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_write,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [BEAT_W-1:0] mem_wdata,
  output logic              mem_wdata_last,
  input  logic              mem_rdata_valid,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_rdata_last
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_W / 8 - 1));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_CMD  = 3'd1,
    WB_DATA = 3'd2,
    RD_CMD  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                     state;
  logic [CNT_W-1:0]           beat;
  logic [CNT_W-1:0]           beat_inc;
  logic [ADDR_W-1:0]          req_addr_q;
  logic [LINE_W-1:0]          wb_buf;
  logic [LINE_W-BEAT_W-1:0]   line_buf;

  assign beat_inc = beat + 1'b1;

  // Victim beats are shifted out of the bottom of wb_buf; refill beats are
  // shifted in at the top of line_buf so beat 0 lands in bits [63:0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      beat            <= '0;
      req_addr_q      <= '0;
      wb_buf          <= '0;
      line_buf        <= '0;
      req_ready       <= 1'b1;
      busy            <= 1'b0;
      err             <= 1'b0;
      ram_ready       <= 1'b0;
      ram_in          <= '0;
      mem_cmd_valid   <= 1'b0;
      mem_cmd_write   <= 1'b0;
      mem_cmd_addr    <= '0;
      mem_wdata_valid <= 1'b0;
      mem_wdata       <= '0;
      mem_wdata_last  <= 1'b0;
    end else begin
      ram_ready <= 1'b0;
      if (mem_rdata_valid && state != RD_DATA) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            req_addr_q    <= req_addr & LINE_MASK;
            wb_buf        <= wb_data;
            req_ready     <= 1'b0;
            busy          <= 1'b1;
            mem_cmd_valid <= 1'b1;
            if (wb_valid) begin
              state         <= WB_CMD;
              mem_cmd_write <= 1'b1;
              mem_cmd_addr  <= wb_addr & LINE_MASK;
            end else begin
              state         <= RD_CMD;
              mem_cmd_write <= 1'b0;
              mem_cmd_addr  <= req_addr & LINE_MASK;
            end
          end
        end

        WB_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid   <= 1'b0;
            mem_cmd_write   <= 1'b0;
            mem_wdata_valid <= 1'b1;
            mem_wdata       <= wb_buf[BEAT_W-1:0];
            mem_wdata_last  <= 1'b0;
            wb_buf          <= wb_buf >> BEAT_W;
            beat            <= '0;
            state           <= WB_DATA;
          end
        end

        WB_DATA: begin
          if (mem_wdata_ready) begin
            if (beat == LAST_BEAT) begin
              mem_wdata_valid <= 1'b0;
              mem_wdata_last  <= 1'b0;
              mem_cmd_valid   <= 1'b1;
              mem_cmd_write   <= 1'b0;
              mem_cmd_addr    <= req_addr_q;
              state           <= RD_CMD;
            end else begin
              beat           <= beat_inc;
              mem_wdata      <= wb_buf[BEAT_W-1:0];
              mem_wdata_last <= (beat_inc == LAST_BEAT);
              wb_buf         <= wb_buf >> BEAT_W;
            end
          end
        end

        RD_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            beat          <= '0;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (mem_rdata_valid) begin
            line_buf <= {mem_rdata, line_buf[LINE_W-BEAT_W-1:BEAT_W]};
            beat     <= beat_inc;
            // A misplaced last flag is only reported; the beat count governs.
            if (mem_rdata_last != (beat == LAST_BEAT)) begin
              err <= 1'b1;
            end
            if (beat == LAST_BEAT) begin
              ram_in    <= {mem_rdata, line_buf};
              ram_ready <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_fill.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_line_fill
// Purpose : Randomized self-checking bench for cache_line_fill with a
//           transaction-level memory/reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_line_fill;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 512;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 8;
  localparam logic [ADDR_W-1:0] MASK = 32'hFFFF_FFC0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              wb_valid = 1'b0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [LINE_W-1:0] wb_data = '0;
  logic              ram_ready;
  logic [LINE_W-1:0] ram_in;
  logic              busy;
  logic              err;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready = 1'b0;
  logic              mem_cmd_write;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic              mem_wdata_valid;
  logic              mem_wdata_ready = 1'b0;
  logic [BEAT_W-1:0] mem_wdata;
  logic              mem_wdata_last;
  logic              mem_rdata_valid = 1'b0;
  logic [BEAT_W-1:0] mem_rdata = '0;
  logic              mem_rdata_last = 1'b0;

  always #5 clk = ~clk;

  cache_line_fill #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ram_ready(ram_ready), .ram_in(ram_in), .busy(busy), .err(err),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_wdata_last(mem_wdata_last),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .mem_rdata_last(mem_rdata_last)
  );

  int   checks   = 0;
  int   failures = 0;
  logic exp_err  = 1'b0;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One complete transaction. The bench plays memory: rd_line is what memory
  // holds at ra, and every wait cycle it injects is counted into the latency.
  task automatic run_txn(input bit wb, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] wa,
                         input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd_line,
                         input int cmd_stall, input bit w_toggle, input bit rd_gaps,
                         input int bad_last_beat, input bit hold_req, input int abort_beat);
    int cyc, stalls, wbeat, rbeat, ncmd, stall_left;
    bit rd_phase, done, cmd_stalled, w_stalled, wtog, expw;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_write;
    logic [BEAT_W-1:0] prev_wdata;
    logic              prev_last;

    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
    check("idle_busy", busy, 0);
    check("ram_ready_pulse", ram_ready, 0);
    req_valid = 1'b1; req_addr = ra; wb_valid = wb; wb_addr = wa; wb_data = wd;
    mem_cmd_ready = 0; mem_wdata_ready = 0; mem_rdata_valid = 0; mem_rdata_last = 0;
    cyc = 0; stalls = 0; wbeat = 0; rbeat = 0; ncmd = 0; stall_left = cmd_stall;
    rd_phase = 0; done = 0; cmd_stalled = 0; w_stalled = 0; wtog = 0;
    prev_addr = '0; prev_write = 0; prev_wdata = '0; prev_last = 0;
    @(posedge clk);

    while (!done) begin
      @(negedge clk);
      cyc++;
      req_valid = hold_req;
      if (cyc == 1) begin
        req_addr = $urandom; wb_addr = $urandom; wb_data = rand_line(); wb_valid = $urandom;
      end
      mem_cmd_ready = 0; mem_wdata_ready = 0; mem_rdata_valid = 0; mem_rdata_last = 0;
      mem_rdata = {$urandom, $urandom};

      check("busy_in_txn", busy, 1);
      check("req_ready_in_txn", req_ready, 0);
      if (cmd_stalled) begin
        check("cmd_hold_valid", mem_cmd_valid, 1);
        check("cmd_hold_addr", mem_cmd_addr, prev_addr);
        check("cmd_hold_write", mem_cmd_write, prev_write);
      end
      if (w_stalled) begin
        check("wdata_hold_valid", mem_wdata_valid, 1);
        check("wdata_hold_data", mem_wdata, prev_wdata);
        check("wdata_hold_last", mem_wdata_last, prev_last);
      end
      cmd_stalled = 0; w_stalled = 0;

      if (cyc > 400) begin
        check("txn_timeout", 0, 1);
        done = 1;
      end else if (ram_ready) begin
        check("ram_ready_latency", cyc, 10 + (wb ? 9 : 0) + stalls);
        check("rd_beats_used", rbeat, BEATS);
        check("ram_in_line", ram_in, rd_line);
        check("err_flag", err, exp_err);
        done = 1;
      end else if (mem_cmd_valid) begin
        expw = wb && (ncmd == 0);
        check("cmd_write", mem_cmd_write, expw);
        check("cmd_addr", mem_cmd_addr, expw ? (wa & MASK) : (ra & MASK));
        if (!expw && wb) check("wb_before_rd", wbeat, BEATS);
        if (stall_left > 0) begin
          stall_left--; stalls++; cmd_stalled = 1;
          prev_addr = mem_cmd_addr; prev_write = mem_cmd_write;
        end else begin
          mem_cmd_ready = 1; ncmd++; stall_left = cmd_stall;
          if (!expw) rd_phase = 1;
        end
      end else if (mem_wdata_valid) begin
        check("wbeat_range", wbeat < BEATS, 1);
        if (wbeat < BEATS) begin
          check("wdata", mem_wdata, wd[wbeat*BEAT_W +: BEAT_W]);
          check("wdata_last", mem_wdata_last, wbeat == BEATS - 1);
        end
        wtog = w_toggle ? !wtog : 1'b1;
        if (wtog) begin
          mem_wdata_ready = 1; wbeat++;
        end else begin
          stalls++; w_stalled = 1;
          prev_wdata = mem_wdata; prev_last = mem_wdata_last;
        end
      end else if (rd_phase && rbeat < BEATS) begin
        if (abort_beat >= 0 && rbeat == abort_beat) begin
          rst = 0;
          #1;
          exp_err = 0;
          check("abort_busy", busy, 0);
          check("abort_req_ready", req_ready, 1);
          check("abort_ram_ready", ram_ready, 0);
          check("abort_cmd_valid", mem_cmd_valid, 0);
          check("abort_err", err, 0);
          req_valid = 0;
          repeat (2) begin
            @(negedge clk);
            check("abort_no_ram_ready", ram_ready, 0);
          end
          rst = 1;
          done = 1;
        end else if (rd_gaps && $urandom_range(0, 3) == 0) begin
          stalls++;
        end else begin
          mem_rdata_valid = 1;
          mem_rdata = rd_line[rbeat*BEAT_W +: BEAT_W];
          mem_rdata_last = (rbeat == BEATS - 1) || (rbeat == bad_last_beat);
          if (rbeat == bad_last_beat && bad_last_beat != BEATS - 1) exp_err = 1;
          rbeat++;
        end
      end else begin
        // DUT neither requests nor completes: the bench inserted no wait here.
        check("unexpected_idle_cycle", 0, 1);
      end
    end
    req_valid = 0;
  endtask

  initial begin
    logic [LINE_W-1:0] l1, l2;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ram_ready", ram_ready, 0);
    check("rst_err", err, 0);
    check("rst_cmd_valid", mem_cmd_valid, 0);
    check("rst_cmd_write", mem_cmd_write, 0);
    check("rst_cmd_addr", mem_cmd_addr, 0);
    check("rst_wdata_valid", mem_wdata_valid, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wdata_last", mem_wdata_last, 0);
    check("rst_ram_in", ram_in, 0);
    rst = 1;

    // refill only, fixed pattern
    for (int k = 0; k < BEATS; k++) l1[k*BEAT_W +: BEAT_W] = 64'h1111_1111_1111_1111 * k;
    run_txn(0, 32'h0000_1A47, 32'h0, '0, l1, 0, 0, 0, -1, 0, -1);
    check("refill_lo", ram_in[63:0], 64'h0);
    check("refill_hi", ram_in[511:448], 64'h7777_7777_7777_7777);

    // dirty eviction
    for (int k = 0; k < BEATS; k++) l2[k*BEAT_W +: BEAT_W] = 64'(k);
    run_txn(1, 32'h0000_3005, 32'h0000_2000, l2, rand_line(), 0, 0, 0, -1, 0, -1);

    // backpressure on command and write-data channels
    run_txn(1, $urandom, $urandom, rand_line(), rand_line(), 3, 1, 0, -1, 0, -1);

    // request held while busy, then accepted right after DONE
    run_txn(1, $urandom, $urandom, rand_line(), rand_line(), 0, 0, 0, -1, 1, -1);
    run_txn(0, $urandom, $urandom, rand_line(), rand_line(), 0, 0, 0, -1, 0, -1);

    for (int i = 0; i < 6; i++) begin
      run_txn($urandom_range(0, 1), $urandom, $urandom, rand_line(), rand_line(),
              $urandom_range(0, 2), $urandom_range(0, 1), 1, -1, 0, -1);
    end

    // reset after beat 4, then a clean refill
    run_txn(0, $urandom, $urandom, rand_line(), rand_line(), 0, 0, 0, -1, 0, 5);
    run_txn(1, $urandom, $urandom, rand_line(), rand_line(), 1, 0, 1, -1, 0, -1);

    // stray read beat while idle
    @(negedge clk);
    check("pre_stray_err", err, 0);
    mem_rdata_valid = 1; mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    mem_rdata_valid = 0;
    exp_err = 1;
    check("stray_err", err, 1);
    check("stray_busy", busy, 0);

    // misplaced last flag; refill must still complete after 8 beats
    run_txn(0, $urandom, $urandom, rand_line(), rand_line(), 0, 0, 0, 3, 0, -1);
    run_txn(1, $urandom, $urandom, rand_line(), rand_line(), 0, 1, 1, -1, 0, -1);
    check("err_sticky", err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
